// File: rtl/dmem_pkg.sv
// Shared types for the data-memory controller: bus command encoding,
// RISC-V load/store funct3 codes and controller state encoding.
package dmem_pkg;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_LOAD  = 2'b01,
    CMD_STORE = 2'b10
  } bus_cmd_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store replication and byte enables,
// load byte/half select with sign/zero extension, misalign/illegal detect.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  logic        w_bad;
  logic        w_mis;
  logic [3:0]  w_st_be;
  logic [31:0] w_shift;

  assign w_shift = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    w_bad   = 1'b0;
    w_mis   = 1'b0;
    w_st_be = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    case (i_funct3)
      F3_B: begin
        w_st_be = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_shift[7]}}, w_shift[7:0]};
      end
      F3_H: begin
        w_mis   = i_addr_lo[0];
        w_st_be = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{w_shift[15]}}, w_shift[15:0]};
      end
      F3_W: begin
        w_mis = (i_addr_lo != 2'b00);
      end
      F3_BU: begin
        w_bad   = i_is_store;
        o_rdata = {24'd0, w_shift[7:0]};
      end
      F3_HU: begin
        w_bad   = i_is_store;
        w_mis   = i_addr_lo[0];
        o_rdata = {16'd0, w_shift[15:0]};
      end
      default: w_bad = 1'b1;
    endcase
  end

  assign o_be  = i_is_store ? w_st_be : 4'b1111;
  assign o_err = (i_is_load | i_is_store) & (w_bad | w_mis);

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: proc2Dmem bus to req/ack SRAM port with stall,
// timeout and lane steering. Optional posted-write buffer: DMEM_WRITE_BUFFER_EN.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        proc2Dmem_command,
  input  logic [31:0]       proc2Dmem_addr,
  input  logic [31:0]       proc2mem_data,
  input  logic [2:0]        proc2Dmem_funct3,
  output logic [31:0]       mem2proc_data,
  output logic              dmem_stall,
  output logic              dmem_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  dmem_state_e       r_state;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [3:0]        r_mem_be;
  logic [1:0]        r_addr_lo;
  logic [2:0]        r_funct3;
  logic [31:0]       r_data;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;

  logic        w_idle, w_is_load, w_is_store, w_cmd, w_legal;
  logic        w_accept, w_posted, w_wb_block;
  logic [1:0]  w_sel_lo;
  logic [2:0]  w_sel_f3;
  logic [31:0] w_al_wdata, w_al_rdata;
  logic [3:0]  w_al_be;
  logic        w_al_err;
  logic        w_unused;

  assign w_unused   = ^proc2Dmem_addr[31:ADDR_W+2];
  assign w_idle     = (r_state == ST_IDLE);
  assign w_is_load  = (proc2Dmem_command == CMD_LOAD);
  assign w_is_store = (proc2Dmem_command == CMD_STORE);
  assign w_cmd      = w_is_load | w_is_store;
  assign w_legal    = w_cmd & ~w_al_err;

  // Live bus drives the aligner only in IDLE; afterwards the latched access does.
  assign w_sel_lo = w_idle ? proc2Dmem_addr[1:0] : r_addr_lo;
  assign w_sel_f3 = w_idle ? proc2Dmem_funct3    : r_funct3;

  dmem_lane_align u_align (
    .i_is_load  (w_idle ? w_is_load  : ~r_mem_we),
    .i_is_store (w_idle ? w_is_store :  r_mem_we),
    .i_addr_lo  (w_sel_lo),
    .i_funct3   (w_sel_f3),
    .i_wdata    (proc2mem_data),
    .i_rdata    (mem_rdata),
    .o_wdata    (w_al_wdata),
    .o_be       (w_al_be),
    .o_rdata    (w_al_rdata),
    .o_err      (w_al_err)
  );

`ifdef DMEM_WRITE_BUFFER_EN
  logic r_wb_valid;
  assign w_wb_block = r_wb_valid;
  assign w_posted   = w_is_store & ~r_wb_valid;
`else
  assign w_wb_block = 1'b0;
  assign w_posted   = 1'b0;
`endif

  assign w_accept = w_idle & w_legal & ~w_wb_block;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_addr_lo   <= '0;
      r_funct3    <= '0;
      r_data      <= '0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
`ifdef DMEM_WRITE_BUFFER_EN
      r_wb_valid  <= 1'b0;
`endif
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_data <= '0;
          if (w_accept) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_is_store;
            r_mem_addr  <= proc2Dmem_addr[ADDR_W+1:2];
            r_mem_wdata <= w_is_store ? w_al_wdata : '0;
            r_mem_be    <= w_al_be;
            r_addr_lo   <= proc2Dmem_addr[1:0];
            r_funct3    <= proc2Dmem_funct3;
            r_cnt       <= '0;
`ifdef DMEM_WRITE_BUFFER_EN
            if (w_posted) r_wb_valid <= 1'b1;
            else          r_state    <= ST_BUSY;
`else
            r_state <= ST_BUSY;
`endif
          end
`ifdef DMEM_WRITE_BUFFER_EN
          // Background drain of the posted store; pipeline keeps running.
          if (r_wb_valid) begin
            if (mem_ack) begin
              r_mem_req  <= 1'b0;
              r_wb_valid <= 1'b0;
            end else if (r_cnt == CNT_LAST) begin
              r_mem_req  <= 1'b0;
              r_wb_valid <= 1'b0;
              r_err      <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
`endif
        end
        ST_BUSY: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_data    <= r_mem_we ? '0 : w_al_rdata;
            r_state   <= ST_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_mem_req <= 1'b0;
            r_err     <= 1'b1;
            r_data    <= '0;
            r_state   <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_data  <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req       = r_mem_req;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign mem_be        = r_mem_be;
  assign mem2proc_data = r_data;
  assign dmem_stall    = rst & ((w_idle & w_legal & ~w_posted) | (r_state == ST_BUSY));
  assign dmem_err      = r_err | (rst & w_idle & w_cmd & w_al_err);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl (default build): spec-level model of per-cycle outputs
// checked every cycle, plus literal checks of observed DUT values.
module tb_dmem_ctrl;

  localparam int unsigned AW = 16;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    cmd;
  logic [31:0]   addr, wdat;
  logic [2:0]    f3;
  logic [31:0]   mem2proc_data;
  logic          dmem_stall, dmem_err, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic [31:0]   mem_rdata;
  logic          mem_ack;

  dmem_ctrl #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk               (clk),
    .rst               (rst),
    .proc2Dmem_command (cmd),
    .proc2Dmem_addr    (addr),
    .proc2mem_data     (wdat),
    .proc2Dmem_funct3  (f3),
    .mem2proc_data     (mem2proc_data),
    .dmem_stall        (dmem_stall),
    .dmem_err          (dmem_err),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_be            (mem_be),
    .mem_rdata         (mem_rdata),
    .mem_ack           (mem_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic          chk_en = 1'b0;
  logic          e_stall, e_err, e_req, e_we;
  logic [31:0]   e_data, e_wdata;
  logic [AW-1:0] e_maddr;
  logic [3:0]    e_be;

  int            obs_stall, obs_req;
  logic          obs_err;
  logic [31:0]   obs_data, obs_wdata;
  logic [AW-1:0] obs_maddr;
  logic [3:0]    obs_be;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: size = 1,2,4 bytes from funct3[1:0]; alignment by modulo.
  function automatic logic f_legal(input logic [1:0] c, input logic [2:0] fn, input logic [31:0] a);
    int unsigned size;
    logic ok;
    size = 1 << fn[1:0];
    if (c == 2'b01)      ok = (fn == 3'd0 || fn == 3'd1 || fn == 3'd2 || fn == 3'd4 || fn == 3'd5);
    else if (c == 2'b10) ok = (fn <= 3'd2);
    else                 ok = 1'b0;
    return ok && ((a % size) == 0);
  endfunction

  function automatic logic [3:0] f_be(input logic st, input logic [2:0] fn, input logic [31:0] a);
    int unsigned size;
    size = 1 << fn[1:0];
    if (!st) return 4'hF;
    return 4'(((1 << size) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] f_wdata(input logic [2:0] fn, input logic [31:0] d);
    if (fn[1:0] == 2'd0) return d[7:0] * 32'h0101_0101;
    if (fn[1:0] == 2'd1) return d[15:0] * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] rd);
    int unsigned size;
    longint v, lim;
    size = 1 << fn[1:0];
    if (size == 4) return rd;
    lim = 64'd1 << (8 * size);
    v   = ({32'd0, rd} >> (8 * (a % 4))) % lim;
    if (!fn[2] && v >= lim / 2) v = v - lim;
    return v[31:0];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", {31'd0, dmem_stall}, {31'd0, e_stall});
      check("err", {31'd0, dmem_err}, {31'd0, e_err});
      check("req", {31'd0, mem_req}, {31'd0, e_req});
      check("rdata_out", mem2proc_data, e_data);
      if (e_req) begin
        check("we", {31'd0, mem_we}, {31'd0, e_we});
        check("maddr", 32'(mem_addr), 32'(e_maddr));
        check("be", {28'd0, mem_be}, {28'd0, e_be});
        if (e_we) check("wdata", mem_wdata, e_wdata);
      end
    end
  end

  task automatic observe();
    @(negedge clk);
    if (dmem_stall) obs_stall++;
    if (mem_req) begin
      obs_req++;
      obs_maddr = mem_addr;
      obs_be    = mem_be;
      obs_wdata = mem_wdata;
    end
    if (dmem_err) obs_err = 1'b1;
  endtask

  // ack_at: BUSY cycle (1-based) carrying mem_ack; 0 = never (timeout + late ack).
  task automatic access(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] fn, input int ack_at, input logic [31:0] rd);
    logic legal, st;
    int   nb;
    legal = f_legal(c, fn, a);
    st    = (c == 2'b10);
    obs_stall = 0; obs_req = 0; obs_err = 1'b0; obs_data = '0;
    @(posedge clk); #1;
    cmd = c; addr = a; wdat = d; f3 = fn; mem_ack = 1'b0;
    e_req = 1'b0; e_stall = legal; e_err = (c == 2'b01 || c == 2'b10) && !legal; e_data = '0;
    e_we = st; e_maddr = a[AW+1:2]; e_wdata = f_wdata(fn, d); e_be = f_be(st, fn, a);
    observe();
    if (legal) begin
      nb = (ack_at == 0) ? TO : ack_at;
      for (int k = 1; k <= nb; k++) begin
        @(posedge clk); #1;
        cmd = 2'($urandom); addr = $urandom; wdat = $urandom; f3 = 3'($urandom);
        mem_ack   = (k == ack_at);
        mem_rdata = (k == ack_at) ? rd : $urandom;
        e_req = 1'b1; e_stall = 1'b1; e_err = 1'b0; e_data = '0;
        observe();
      end
      @(posedge clk); #1;
      cmd = 2'b00; mem_ack = 1'b0;
      e_req = 1'b0; e_stall = 1'b0; e_err = (ack_at == 0);
      e_data = (ack_at != 0 && !st) ? f_load(fn, a, rd) : 32'd0;
      observe();
      obs_data = mem2proc_data;
    end
    @(posedge clk); #1;
    cmd = 2'b00; mem_ack = (legal && ack_at == 0); mem_rdata = 32'hDEAD_BEEF;
    e_req = 1'b0; e_stall = 1'b0; e_err = 1'b0; e_data = '0;
    observe();
  endtask

  initial begin
    rst = 1'b0; cmd = 2'b01; addr = 32'h10; wdat = '0; f3 = 3'd2;
    mem_rdata = '0; mem_ack = 1'b0;
    e_req = 1'b0; e_stall = 1'b0; e_err = 1'b0; e_data = '0;
    e_we = 1'b0; e_maddr = '0; e_wdata = '0; e_be = '0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_maddr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_be", {28'd0, mem_be}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; cmd = 2'b00;
    observe();

    access(2'b10, 32'h0000_0010, 32'h1234_5678, 3'd2, 3, 32'd0);
    check("sw_maddr", 32'(obs_maddr), 32'd4);
    check("sw_be", {28'd0, obs_be}, 32'hF);
    check("sw_wdata", obs_wdata, 32'h1234_5678);
    check("sw_stall_cycles", obs_stall, 4);
    check("sw_err", {31'd0, obs_err}, 32'd0);

    access(2'b10, 32'h13, 32'h0000_00AB, 3'd0, 1, 32'd0);
    check("sb_be", {28'd0, obs_be}, 32'h8);
    check("sb_wdata", obs_wdata, 32'hABAB_ABAB);
    access(2'b01, 32'h13, 32'd0, 3'd0, 2, 32'hAB00_0000);
    check("lb_data", obs_data, 32'hFFFF_FFAB);
    access(2'b01, 32'h13, 32'd0, 3'd4, 1, 32'hAB00_0000);
    check("lbu_data", obs_data, 32'h0000_00AB);
    access(2'b01, 32'h22, 32'd0, 3'd1, 1, 32'h8001_0000);
    check("lh_data", obs_data, 32'hFFFF_8001);
    access(2'b01, 32'h22, 32'd0, 3'd5, 4, 32'h8001_0000);
    check("lhu_data", obs_data, 32'h0000_8001);
    access(2'b10, 32'h22, 32'h0000_BEEF, 3'd1, 1, 32'd0);
    check("sh_be", {28'd0, obs_be}, 32'hC);
    check("sh_wdata", obs_wdata, 32'hBEEF_BEEF);
    access(2'b01, 32'h40, 32'd0, 3'd2, 5, 32'hCAFE_F00D);
    check("lw_data", obs_data, 32'hCAFE_F00D);

    access(2'b01, 32'h06, 32'd0, 3'd2, 1, 32'd0);
    check("lw_mis_err", {31'd0, obs_err}, 32'd1);
    check("lw_mis_req", obs_req, 0);
    check("lw_mis_stall", obs_stall, 0);
    access(2'b10, 32'h21, 32'h1234, 3'd1, 1, 32'd0);
    access(2'b10, 32'h20, 32'h1234, 3'd4, 1, 32'd0);
    access(2'b01, 32'h20, 32'd0, 3'd3, 1, 32'd0);
    access(2'b01, 32'h20, 32'd0, 3'd6, 1, 32'd0);
    access(2'b11, 32'h20, 32'd0, 3'd2, 1, 32'd0);
    check("cmd11_stall", obs_stall, 0);

    access(2'b01, 32'h08, 32'd0, 3'd2, 0, 32'd0);
    check("to_req_cycles", obs_req, 8);
    check("to_err", {31'd0, obs_err}, 32'd1);
    check("to_data", obs_data, 32'd0);
    access(2'b01, 32'h31, 32'd0, 3'd0, 8, 32'h0000_7F00);
    check("ack_at_limit_err", {31'd0, obs_err}, 32'd0);
    check("ack_at_limit_data", obs_data, 32'h0000_007F);

    // Reset during BUSY
    @(posedge clk); #1;
    cmd = 2'b01; addr = 32'h100; f3 = 3'd2;
    e_stall = 1'b1; e_req = 1'b0; e_err = 1'b0; e_data = '0;
    e_we = 1'b0; e_maddr = 16'h40; e_be = 4'hF;
    observe();
    @(posedge clk); #1;
    e_req = 1'b1;
    observe();
    @(posedge clk); #1;
    rst = 1'b0;
    e_req = 1'b0; e_stall = 1'b0;
    observe();
    check("rst_busy_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; cmd = 2'b00; mem_ack = 1'b1;
    observe();
    @(posedge clk); #1;
    mem_ack = 1'b0;
    observe();
    access(2'b01, 32'h44, 32'd0, 3'd1, 1, 32'h1234_5678);
    check("post_rst_lh", obs_data, 32'h0000_5678);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
